// File: rtl/dec_pkg.sv
// dec_pkg: shared FSM state, mode encodings and default widths for dec_scan
package dec_pkg;
  localparam int IN_W_DEF    = 3;
  localparam int DWELL_W_DEF = 4;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: MSB-first index to one-hot decode (index 0 -> top bit)
module dec_onehot
  import dec_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0]      idx,
  output logic [2**IN_W-1:0]   y
);
  always_comb begin
    y = '0;
    y[~idx] = 1'b1;
  end
endmodule

// File: rtl/dec_scan.sv
// dec_scan: direct one-hot decoder with an auto-scan mode.
// Define DEC_SCAN_DWELL_EN to hold each scan step for dwell+1 cycles.
module dec_scan
  import dec_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     idx,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**IN_W-1:0]  y,
  output logic                y_valid,
  output logic                wrap
);
  localparam int OUT_W = 2**IN_W;
  state_t state_q, state_d;
  logic [IN_W-1:0] sidx_q, sidx_d, oh_idx;
  logic [OUT_W-1:0] y_q, y_d, oh_y;
  logic y_valid_q, y_valid_d, wrap_q, wrap_d, accept, step;
  assign in_ready = !en && mode == MODE_DIRECT;
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // A mode change always passes through IDLE for one cycle.
  always_comb begin
    state_d = en ? IDLE :
              state_q == IDLE   ? (mode == MODE_SCAN ? SCAN : DIRECT) :
              state_q == DIRECT ? (mode == MODE_SCAN ? IDLE : DIRECT) :
                                  (mode == MODE_SCAN ? SCAN : IDLE);
  end
`ifdef DEC_SCAN_DWELL_EN
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  assign step = cnt_q == '0;
  // dwell is sampled only when a step is loaded.
  always_comb begin
    cnt_d = state_d != SCAN ? '0 :
            (state_q != SCAN || step) ? dwell : cnt_q - DWELL_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic dwell_unused;
  assign dwell_unused = ^dwell;
  assign step = 1'b1;
`endif
  always_comb begin
    sidx_d = (state_d != SCAN || state_q != SCAN) ? '0 :
             step ? sidx_q + IN_W'(1) : sidx_q;
    wrap_d = state_q == SCAN && state_d == SCAN && step && sidx_q == '1;
    oh_idx = state_d == SCAN ? sidx_d : idx;
  end
  dec_onehot #(.IN_W(IN_W)) u_onehot (
    .idx (oh_idx),
    .y   (oh_y)
  );
  always_comb begin
    y_d = (state_d == SCAN || (state_d == DIRECT && accept)) ? oh_y :
          (state_d == DIRECT && state_q == DIRECT) ? y_q : '0;
    y_valid_d = state_d == SCAN ||
                (state_d == DIRECT && (accept || (state_q == DIRECT && y_valid_q)));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      sidx_q    <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      sidx_q    <= sidx_d;
    end
  end
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: randomized self-checking bench for dec_scan against a behavioural model
module tb_dec_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] idx = '0;
  logic [3:0] dwell = '0;
  logic in_ready, y_valid, wrap;
  logic [7:0] y;
  int tests = 0;
  int fails = 0;
  int m_phase = 0;
  int m_pos = 0;
  int m_left = 0;
  int m_y = -1;
  int m_wrap = 0;

  always #5 clk = ~clk;

  dec_scan #(.IN_W(3), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .idx(idx), .dwell(dwell), .y(y), .y_valid(y_valid), .wrap(wrap)
  );

  function automatic logic [7:0] exp_y();
    return m_y < 0 ? 8'h00 : 8'(8'h80 >> m_y);
  endfunction

  // Model: phase 0 idle, 1 direct, 2 scan; m_y is the displayed index or -1.
  task automatic tick();
    int de;
    @(posedge clk);
`ifdef DEC_SCAN_DWELL_EN
    de = int'(dwell);
`else
    de = 0;
`endif
    if (!rst_n || en) begin
      m_phase = 0; m_y = -1; m_wrap = 0;
    end else if (m_phase == 0) begin
      m_phase = mode ? 2 : 1; m_wrap = 0; m_pos = 0; m_left = de;
      m_y = mode ? 0 : (in_valid ? int'(idx) : -1);
    end else if ((m_phase == 2) != mode) begin
      m_phase = 0; m_y = -1; m_wrap = 0;
    end else if (m_phase == 1) begin
      if (in_valid) m_y = int'(idx);
    end else begin
      if (m_left == 0) begin
        m_pos = (m_pos + 1) % 8; m_left = de; m_wrap = (m_pos == 0) ? 1 : 0;
      end else begin
        m_left--; m_wrap = 0;
      end
      m_y = m_pos;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; mode = 1'($urandom_range(0, 1)); in_valid = 1;
    tick(); tick();
    tests++;
    if (y !== 8'h00 || y_valid !== 1'b0 || wrap !== 1'b0) begin
      $display("FAIL reset: y=%b v=%b w=%b expected 0 0 0", y, y_valid, wrap); fails++;
    end
    en = 1; in_valid = 0; rst_n = 1;
    tick();
  endtask

  task automatic test_direct();
    en = 0; mode = 0; in_valid = 1; idx = 3'd5;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL direct_ready: in_ready=%b expected 1", in_ready); fails++;
    end
    tick();
    tests++;
    if (y !== 8'b00000100 || y_valid !== 1'b1) begin
      $display("FAIL direct_idx5: y=%b v=%b expected 00000100 1", y, y_valid); fails++;
    end
    idx = 3'd0;
    tick();
    tests++;
    if (y !== 8'b10000000 || y_valid !== 1'b1) begin
      $display("FAIL direct_idx0: y=%b v=%b expected 10000000 1", y, y_valid); fails++;
    end
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1)); idx = 3'($urandom);
      tick();
      tests++;
      if (y !== exp_y() || y_valid !== (m_y >= 0) || wrap !== 1'b0) begin
        $display("FAIL direct_rand: y=%b v=%b w=%b expected y=%b v=%b w=0", y, y_valid, wrap, exp_y(), m_y >= 0); fails++;
      end
    end
  endtask

  task automatic test_disable();
    en = 0; mode = 0; in_valid = 1; idx = 3'd3;
    tick();
    tests++;
    if (y !== 8'b00010000) begin
      $display("FAIL disable_setup: y=%b expected 00010000", y); fails++;
    end
    en = 1; in_valid = 1; idx = 3'd6;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      $display("FAIL disable_ready: in_ready=%b expected 0", in_ready); fails++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (y !== 8'h00 || y_valid !== 1'b0 || wrap !== 1'b0) begin
        $display("FAIL disable_out: y=%b v=%b w=%b expected 0 0 0", y, y_valid, wrap); fails++;
      end
    end
    in_valid = 0;
  endtask

  task automatic test_scan();
    logic [7:0] e;
    en = 1; dwell = 0; in_valid = 0;
    tick();
    en = 0; mode = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = 8'(8'h80 >> (i % 8));
      tests++;
      if (y !== e || y_valid !== 1'b1 || wrap !== (i == 8)) begin
        $display("FAIL scan_seq%0d: y=%b v=%b w=%b expected y=%b v=1 w=%b", i, y, y_valid, wrap, e, i == 8); fails++;
      end
    end
  endtask

  task automatic test_dwell();
    en = 1;
`ifdef DEC_SCAN_DWELL_EN
    dwell = 4'd2;
`else
    dwell = 4'($urandom_range(1, 15));
`endif
    tick();
    en = 0; mode = 1;
    for (int i = 0; i < 40; i++) begin
`ifdef DEC_SCAN_DWELL_EN
      if (i == 7) dwell = 4'd0;
      if (i == 25) dwell = 4'($urandom_range(0, 3));
`else
      dwell = 4'($urandom);
`endif
      tick();
      tests++;
      if (y !== exp_y() || y_valid !== 1'b1 || wrap !== m_wrap[0] || $countones(y) != 1) begin
        $display("FAIL dwell_step%0d: y=%b v=%b w=%b expected y=%b v=1 w=%0d", i, y, y_valid, wrap, exp_y(), m_wrap); fails++;
      end
    end
  endtask

  task automatic test_mode_switch();
    en = 1; dwell = 0; in_valid = 0;
    tick();
    en = 0; mode = 1;
    tick(); tick(); tick();
    tests++;
    if (y !== 8'b00100000) begin
      $display("FAIL switch_setup: y=%b expected 00100000", y); fails++;
    end
    mode = 0;
    tick();
    tests++;
    if (y !== 8'h00 || y_valid !== 1'b0) begin
      $display("FAIL switch_gap: y=%b v=%b expected 0 0", y, y_valid); fails++;
    end
    in_valid = 1; idx = 3'd6;
    tick();
    tests++;
    if (y !== 8'b00000010 || y_valid !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL switch_direct: y=%b v=%b rdy=%b expected 00000010 1 1", y, y_valid, in_ready); fails++;
    end
    in_valid = 0; mode = 1;
    tick(); tick(); tick(); tick();
    tests++;
    if (y !== 8'b00100000) begin
      $display("FAIL rst_setup: y=%b expected 00100000", y); fails++;
    end
    rst_n = 0;
    tick();
    tests++;
    if (y !== 8'h00 || y_valid !== 1'b0 || wrap !== 1'b0) begin
      $display("FAIL rst_mid: y=%b v=%b w=%b expected 0 0 0", y, y_valid, wrap); fails++;
    end
    rst_n = 1;
    tick();
    tests++;
    if (y !== 8'b10000000 || y_valid !== 1'b1 || wrap !== 1'b0) begin
      $display("FAIL rst_restart: y=%b v=%b w=%b expected 10000000 1 0", y, y_valid, wrap); fails++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      in_valid = 1'($urandom_range(0, 1));
      idx = 3'($urandom);
      dwell = 4'($urandom_range(0, 3));
      #1;
      tests++;
      if (in_ready !== (!en && !mode)) begin
        $display("FAIL rand_ready%0d: in_ready=%b expected %b", i, in_ready, !en && !mode); fails++;
      end
      tick();
      tests++;
      if (y !== exp_y() || y_valid !== (m_y >= 0) || wrap !== m_wrap[0]) begin
        $display("FAIL rand_out%0d: y=%b v=%b w=%b expected y=%b v=%b w=%0d", i, y, y_valid, wrap, exp_y(), m_y >= 0, m_wrap); fails++;
      end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_disable();
    test_scan();
    test_dwell();
    test_mode_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
